// File: rtl/key_cond_pkg.sv
// Shared types and sizing helpers for the push-button conditioning block.
package key_cond_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    CONFIRM_PRESS,
    HELD,
    REPEATING,
    CONFIRM_RELEASE
  } key_state_t;

  // Width of a counter that must reach the largest of the three delays.
  function automatic int cnt_width(input int deb, input int hold, input int rep);
    int m;
    m = deb;
    if (hold > m) m = hold;
    if (rep > m) m = rep;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing a single asynchronous level into the clock domain.
module sync_2ff (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d,
  output logic q
);

  logic stage1;

  // Two back-to-back flops; both clear on reset so no stale level survives it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronise, debounce, and emit press/release/auto-repeat pulses.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEB_DELAY     = 1000000,
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic key_i,
  output logic debkey_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic next_o
);

  localparam int CNT_W = cnt_width(DEB_DELAY, HOLD_DELAY, REPEAT_PERIOD);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             key_s;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d      (key_i),
    .q      (key_s)
  );

  // Debounce/repeat FSM with a shared counter cleared on every state entry; all outputs registered.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= RELEASED;
      cnt       <= '0;
      debkey_o  <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      repeat_o  <= 1'b0;
      next_o    <= 1'b0;
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      repeat_o  <= 1'b0;
      next_o    <= 1'b0;
      case (state)
        RELEASED: begin
          cnt <= '0;
          if (key_s) state <= CONFIRM_PRESS;
        end
        CONFIRM_PRESS: begin
          if (!key_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state    <= HELD;
            cnt      <= '0;
            press_o  <= 1'b1;
            next_o   <= 1'b1;
            debkey_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!key_s) begin
            state <= CONFIRM_RELEASE;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            // Without auto-repeat the counter parks at the terminal value.
            if (REPEAT_EN) begin
              state    <= REPEATING;
              cnt      <= '0;
              repeat_o <= 1'b1;
              next_o   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        REPEATING: begin
          if (!key_s) begin
            state <= CONFIRM_RELEASE;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            cnt      <= '0;
            repeat_o <= 1'b1;
            next_o   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        CONFIRM_RELEASE: begin
          if (key_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= RELEASED;
            cnt       <= '0;
            release_o <= 1'b1;
            debkey_o  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= RELEASED;
          cnt      <= '0;
          debkey_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench: directed scenarios plus randomized key activity against a behavioural model.
module tb_key_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int PER  = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic key = 1'b0;

  logic a_debkey, a_press, a_release, a_repeat, a_next;
  logic b_debkey, b_press, b_release, b_repeat, b_next;

  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .DEB_DELAY(DEB), .HOLD_DELAY(HOLD), .REPEAT_PERIOD(PER), .REPEAT_EN(1'b1)
  ) dut_rep (
    .clk_i(clk), .rstn_i(rstn), .key_i(key),
    .debkey_o(a_debkey), .press_o(a_press), .release_o(a_release),
    .repeat_o(a_repeat), .next_o(a_next)
  );

  key_conditioner #(
    .DEB_DELAY(DEB), .HOLD_DELAY(HOLD), .REPEAT_PERIOD(PER), .REPEAT_EN(1'b0)
  ) dut_norep (
    .clk_i(clk), .rstn_i(rstn), .key_i(key),
    .debkey_o(b_debkey), .press_o(b_press), .release_o(b_release),
    .repeat_o(b_repeat), .next_o(b_next)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural model: the synchronised level must persist DEB+1 samples to flip the
  // debounced state; repeats fall at HOLD, HOLD+PER, ... uninterrupted samples after press.
  logic m_s1, m_s2, m_ks, m_pressed;
  int   m_run, m_hold;
  logic e_press, e_release, e_repeat;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_s1 = 0; m_s2 = 0; m_pressed = 0; m_run = 0; m_hold = 0;
      e_press = 0; e_release = 0; e_repeat = 0;
    end else begin
      m_ks = m_s2;
      m_s2 = m_s1;
      m_s1 = key;
      e_press = 0; e_release = 0; e_repeat = 0;
      if (!m_pressed) begin
        m_run = m_ks ? m_run + 1 : 0;
        if (m_run == DEB + 1) begin
          e_press = 1; m_pressed = 1; m_run = 0; m_hold = 0;
        end
      end else if (!m_ks) begin
        m_run = m_run + 1;
        if (m_run == DEB + 1) begin
          e_release = 1; m_pressed = 0; m_run = 0;
        end
      end else begin
        m_hold = (m_run > 0) ? 0 : m_hold + 1;
        m_run = 0;
        if (m_hold >= HOLD && ((m_hold - HOLD) % PER) == 0) e_repeat = 1;
      end
    end
  end

  wire [4:0] obs_a = {a_debkey, a_press, a_release, a_repeat, a_next};
  wire [4:0] obs_b = {b_debkey, b_press, b_release, b_repeat, b_next};
  wire [4:0] exp_a = {m_pressed, e_press, e_release, e_repeat, e_press | e_repeat};
  wire [4:0] exp_b = {m_pressed, e_press, e_release, 1'b0, e_press};

  task automatic test_reset();
    rstn = 1'b0;
    key  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({obs_a, obs_b} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got=%b want=%b", {obs_a, obs_b}, 10'b0);
    end
    rstn = 1'b1;
    key  = 1'b1;
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({obs_a, obs_b} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_press got=%b want=%b", {obs_a, obs_b}, 10'b0);
    end
    @(negedge clk);
    key = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("[TB] FAIL after_reset cyc=%0d got=%b want=%b", i, {obs_a, obs_b}, {exp_a, exp_b});
      end
      checks++;
      if (a_press !== 1'b0 || a_debkey !== 1'b0) begin
        errors++;
        $display("[TB] FAIL no_press_after_reset cyc=%0d got=%b%b want=00", i, a_press, a_debkey);
      end
    end
  endtask

  task automatic test_clean_press();
    int press_at = -1, presses = 0, nexts = 0, reps = 0, deb_at = -1;
    key = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("[TB] FAIL press_model cyc=%0d got=%b want=%b", i, {obs_a, obs_b}, {exp_a, exp_b});
      end
      if (a_press) begin presses++; press_at = i; end
      if (a_next) nexts++;
      if (a_repeat) reps++;
      if (a_debkey && deb_at < 0) deb_at = i;
    end
    checks++;
    if (press_at !== 7 || presses !== 1 || nexts !== 1 || reps !== 0 || deb_at !== 7) begin
      errors++;
      $display("[TB] FAIL press_timing got at=%0d n=%0d next=%0d rep=%0d deb=%0d want 7/1/1/0/7",
               press_at, presses, nexts, reps, deb_at);
    end
    key = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("[TB] FAIL press_drain cyc=%0d got=%b want=%b", i, {obs_a, obs_b}, {exp_a, exp_b});
      end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0, deb_seen = 0;
    for (int i = 0; i < 20; i++) begin
      key = (i < 8) ? ((i / 2) % 2 == 0) : 1'b0;
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("[TB] FAIL bounce_model cyc=%0d got=%b want=%b", i, {obs_a, obs_b}, {exp_a, exp_b});
      end
      pulses += int'(a_press) + int'(a_release) + int'(a_repeat) + int'(a_next);
      deb_seen += int'(a_debkey);
    end
    checks++;
    if (pulses !== 0 || deb_seen !== 0) begin
      errors++;
      $display("[TB] FAIL bounce_quiet got pulses=%0d debkey=%0d want 0/0", pulses, deb_seen);
    end
  endtask

  task automatic test_long_hold();
    int press_at = -1, reps = 0, bad_rep = 0, nexts = 0, b_reps = 0;
    key = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("[TB] FAIL hold_model cyc=%0d got=%b want=%b", i, {obs_a, obs_b}, {exp_a, exp_b});
      end
      if (a_press) press_at = i;
      if (a_next) nexts++;
      if (b_repeat) b_reps++;
      if (a_repeat) begin
        reps++;
        if (press_at < 0 || i - press_at < HOLD || ((i - press_at - HOLD) % PER) != 0) bad_rep++;
      end
    end
    checks++;
    if (press_at !== 7 || reps !== 5 || bad_rep !== 0 || nexts !== 6) begin
      errors++;
      $display("[TB] FAIL repeat_schedule got press=%0d reps=%0d misplaced=%0d next=%0d want 7/5/0/6",
               press_at, reps, bad_rep, nexts);
    end
    checks++;
    if (b_reps !== 0) begin
      errors++;
      $display("[TB] FAIL repeat_disabled got=%0d want=0", b_reps);
    end
  endtask

  task automatic test_release_glitch();
    int first_rep = -1, releases = 0, deb_low = 0;
    key = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("[TB] FAIL glitch_model cyc=%0d got=%b want=%b", i, {obs_a, obs_b}, {exp_a, exp_b});
      end
      if (a_release || b_release) releases++;
      if (!a_debkey) deb_low++;
      if (a_repeat && i >= 3 && first_rep < 0) first_rep = i;
      if (i == 2) key = 1'b1;
    end
    checks++;
    if (releases !== 0 || deb_low !== 0 || first_rep !== 15) begin
      errors++;
      $display("[TB] FAIL glitch_restart got rel=%0d deblow=%0d rep=%0d want 0/0/15",
               releases, deb_low, first_rep);
    end
  endtask

  task automatic test_clean_release();
    int rel_at = -1, rels = 0, fall_at = -1, late_rep = 0;
    logic prev_deb;
    prev_deb = a_debkey;
    key = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("[TB] FAIL release_model cyc=%0d got=%b want=%b", i, {obs_a, obs_b}, {exp_a, exp_b});
      end
      if (a_release) begin rels++; rel_at = i; end
      if (prev_deb && !a_debkey) fall_at = i;
      if (a_repeat && i >= 3) late_rep++;
      prev_deb = a_debkey;
    end
    checks++;
    if (rel_at !== 7 || rels !== 1 || fall_at !== 7 || late_rep !== 0) begin
      errors++;
      $display("[TB] FAIL release_timing got at=%0d n=%0d fall=%0d rep=%0d want 7/1/7/0",
               rel_at, rels, fall_at, late_rep);
    end
  endtask

  task automatic test_random();
    int seg = 0;
    logic prev_next = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (seg == 0) begin
        key = ~key;
        seg = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 30) : $urandom_range(1, 5);
      end
      seg--;
      rstn = ($urandom_range(0, 99) != 0);
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("[TB] FAIL random_model cyc=%0d got=%b want=%b", i, {obs_a, obs_b}, {exp_a, exp_b});
      end
      checks++;
      if ($countones({a_press, a_release, a_repeat}) > 1 || (prev_next && a_next)) begin
        errors++;
        $display("[TB] FAIL pulse_exclusive cyc=%0d got=%b%b%b%b want one-hot, no back-to-back next",
                 i, a_press, a_release, a_repeat, a_next);
      end
      prev_next = a_next;
    end
    rstn = 1'b1;
  endtask

  // Run the scenarios in order and report.
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_glitch();
    test_clean_release();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
